coeff_packer: RTL and testbench

- Upstream feeder of the encoder's synchronous FIFO (64-bit data, push/accept, almost_full).
- Collects narrow coefficients from the encoding datapath and packs PER_WORD = DATA_WIDTH/COEFF_WIDTH of them into one FIFO word.
- Zero-pads a partial word at frame end and pushes it under FIFO backpressure.
- Reports frame completion once the last word of a frame has entered the FIFO.

---
 rtl/coeff_packer.sv | 101 ++++++++++
 tb/tb_coeff_packer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/coeff_packer.sv
// Packs PER_WORD narrow coefficients into one FIFO word, zero-padding at frame end.
// Define COEFF_PACKER_MSB_FIRST_EN to place slot 0 at the MSB instead of the LSB.
module coeff_packer #(
  parameter int COEFF_WIDTH = 16,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COEFF_WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_push,
  input  logic                   fifo_accept,
  input  logic                   fifo_almost_full,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int PER_WORD   = DATA_WIDTH / COEFF_WIDTH;
  localparam int SLOT_WIDTH = (PER_WORD > 1) ? $clog2(PER_WORD) : 1;
  localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(PER_WORD - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  generate
    if ((DATA_WIDTH % COEFF_WIDTH) != 0 || PER_WORD < 1) begin : g_bad_width
      $error("coeff_packer: DATA_WIDTH must be an exact multiple of COEFF_WIDTH");
    end
  endgenerate

  logic [0:0]            r_state;
  logic [SLOT_WIDTH-1:0] r_slot;
  logic [DATA_WIDTH-1:0] r_pack;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_pend;
  logic                  r_out_last;
  logic                  r_frame_done;

  logic [DATA_WIDTH-1:0] w_placed;
  logic                  w_beat;
  logic                  w_complete;

  // Each lane is zero unless the current slot selects it, so OR-ing into r_pack fills one slot.
  genvar gi;
  generate
    for (gi = 0; gi < PER_WORD; gi++) begin : g_lane
`ifdef COEFF_PACKER_MSB_FIRST_EN
      localparam int LO = DATA_WIDTH - (gi + 1) * COEFF_WIDTH;
`else
      localparam int LO = gi * COEFF_WIDTH;
`endif
      assign w_placed[LO +: COEFF_WIDTH] = (r_slot == SLOT_WIDTH'(gi)) ? in_data : '0;
    end
  endgenerate

  // Ready depends only on FIFO status so upstream can never deadlock on its own valid.
  assign in_ready   = rst_n & ~fifo_almost_full & (~r_out_pend | fifo_accept);
  assign w_beat     = in_valid & in_ready;
  assign w_complete = (r_slot == LAST_SLOT) | in_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_slot       <= '0;
      r_pack       <= '0;
      r_out_data   <= '0;
      r_out_pend   <= 1'b0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_out_pend & fifo_accept & r_out_last;
      if (r_out_pend && fifo_accept) begin
        r_out_pend <= 1'b0;
      end
      // A completing beat in the same cycle as a handshake reloads the output register.
      if (w_beat) begin
        if (w_complete) begin
          r_out_data <= r_pack | w_placed;
          r_out_pend <= 1'b1;
          r_out_last <= in_last;
          r_pack     <= '0;
          r_slot     <= '0;
          r_state    <= S_IDLE;
        end else begin
          r_pack  <= r_pack | w_placed;
          r_slot  <= r_slot + SLOT_WIDTH'(1);
          r_state <= S_FILL;
        end
      end
    end
  end

  assign fifo_data  = r_out_data;
  assign fifo_push  = r_out_pend;
  assign frame_done = r_frame_done;
  assign busy       = (r_state == S_FILL) | r_out_pend;

endmodule

// File: tb/tb_coeff_packer.sv
// Directed and randomized bench for coeff_packer against a queue-based reference model.
module tb_coeff_packer;

  localparam int CW = 16;
  localparam int DW = 64;
  localparam int PW = DW / CW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic [DW-1:0] fifo_data;
  logic          fifo_push;
  logic          fifo_accept = 1'b0;
  logic          fifo_almost_full = 1'b0;
  logic          frame_done;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;
  int push_count = 0;

  logic [CW-1:0] partial[$];
  word_t         exp_q[$];
  logic          exp_fd = 1'b0;

  coeff_packer #(.COEFF_WIDTH(CW), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_last          (in_last),
    .fifo_data        (fifo_data),
    .fifo_push        (fifo_push),
    .fifo_accept      (fifo_accept),
    .fifo_almost_full (fifo_almost_full),
    .frame_done       (frame_done),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: collect a frame's coefficients and emit a word per PW beats or at frame end.
  task automatic model_beat(input logic [CW-1:0] d, input logic l);
    logic [DW-1:0] w;
    word_t e;
    partial.push_back(d);
    if (partial.size() == PW || l) begin
      w = '0;
      for (int k = 0; k < partial.size(); k++) begin
`ifdef COEFF_PACKER_MSB_FIRST_EN
        w = w | ({{(DW-CW){1'b0}}, partial[k]} << (DW - (k + 1) * CW));
`else
        w = w | ({{(DW-CW){1'b0}}, partial[k]} << (k * CW));
`endif
      end
      e.data = w;
      e.last = l;
      exp_q.push_back(e);
      partial.delete();
    end
  endtask

  // One clock: drive at negedge, check just after, advance model across the posedge.
  task automatic tick(input logic v, input logic [CW-1:0] d, input logic l,
                      input logic acc, input logic af);
    logic exp_rdy;
    logic beat;
    logic pop;
    in_valid = v;
    in_data = d;
    in_last = l;
    fifo_accept = acc;
    fifo_almost_full = af;
    #1;
    exp_rdy = rst_n & ~af & ((exp_q.size() == 0) | acc);
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    check("fifo_push", {63'd0, fifo_push}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) check("fifo_data", fifo_data, exp_q[0].data);
    check("frame_done", {63'd0, frame_done}, {63'd0, exp_fd});
    check("busy", {63'd0, busy}, {63'd0, (partial.size() != 0) || (exp_q.size() != 0)});
    beat = v & exp_rdy;
    pop = (exp_q.size() != 0) & acc;
    @(posedge clk);
    exp_fd = 1'b0;
    if (pop) begin
      exp_fd = exp_q[0].last;
      push_count++;
      void'(exp_q.pop_front());
    end
    if (beat) model_beat(d, l);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    fifo_accept = 1'b1;
    fifo_almost_full = 1'b0;
    #1;
    partial.delete();
    exp_q.delete();
    exp_fd = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_fifo_push", {63'd0, fifo_push}, 64'd0);
    check("rst_fifo_data", fifo_data, 64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    logic [DW-1:0] w_full;
    logic [DW-1:0] w_part;
`ifdef COEFF_PACKER_MSB_FIRST_EN
    w_full = 64'h1111_2222_3333_4444;
    w_part = 64'hAAAA_BBBB_0000_0000;
`else
    w_full = 64'h4444_3333_2222_1111;
    w_part = 64'h0000_0000_BBBB_AAAA;
`endif
    @(negedge clk);
    do_reset();

    // Single full word
    tick(1, 16'h1111, 0, 1, 0);
    tick(1, 16'h2222, 0, 1, 0);
    tick(1, 16'h3333, 0, 1, 0);
    tick(1, 16'h4444, 1, 1, 0);
    check("full_push", {63'd0, fifo_push}, 64'd1);
    check("full_word", fifo_data, w_full);
    tick(0, 0, 0, 1, 0);
    check("full_frame_done", {63'd0, frame_done}, 64'd1);
    tick(0, 0, 0, 1, 0);

    // Partial frame
    tick(1, 16'hAAAA, 0, 1, 0);
    tick(1, 16'hBBBB, 1, 1, 0);
    check("part_word", fifo_data, w_part);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    check("part_busy", {63'd0, busy}, 64'd0);

    // Full-rate streaming, 12 beats
    base = push_count;
    for (int i = 0; i < 12; i++) tick(1, 16'(i * 16'h0101 + 16'h0A0B), (i == 11), 1, 0);
    tick(0, 0, 0, 1, 0);
    check("stream_pushes", 64'(push_count - base), 64'd3);

    // Backpressure with a word pending
    base = push_count;
    for (int i = 0; i < 4; i++) tick(1, 16'(16'hC000 + i), (i == 3), 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 16'hDEAD, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);
    check("bp_single_push", 64'(push_count - base), 64'd1);

    // almost_full mid-word
    tick(1, 16'h0001, 0, 1, 0);
    tick(1, 16'h0002, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick(1, 16'hBAD0, 0, 1, 1);
    tick(1, 16'h0003, 0, 1, 0);
    tick(1, 16'h0004, 1, 1, 0);
`ifdef COEFF_PACKER_MSB_FIRST_EN
    check("af_word", fifo_data, 64'h0001_0002_0003_0004);
`else
    check("af_word", fifo_data, 64'h0004_0003_0002_0001);
`endif
    tick(0, 0, 0, 1, 0);

    // Reset mid-frame
    tick(1, 16'h7777, 0, 1, 0);
    tick(1, 16'h8888, 0, 1, 0);
    tick(1, 16'h9999, 0, 1, 0);
    do_reset();
    tick(1, 16'h1111, 0, 1, 0);
    tick(1, 16'h2222, 0, 1, 0);
    tick(1, 16'h3333, 0, 1, 0);
    tick(1, 16'h4444, 1, 1, 0);
    check("rst_clean_word", fifo_data, w_full);
    tick(0, 0, 0, 1, 0);

    // Randomized traffic with one reset midway
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      tick(($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 6) == 0));
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
